// File: rtl/pipeline_skid_buffer_pkg.sv
// Package: skid_pkg
// Purpose: shared state encoding and widths for pipeline_skid_buffer.
//   The SKID encoding (2) equals the number of held words, so the count output
//   can be read directly from the state register.
package skid_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned COUNT_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

endpackage : skid_pkg

// File: rtl/pipeline_skid_buffer_sync_register.sv
// Module: sync_register
// Purpose: N-bit data register with synchronous active-high reset and load enable.
// Ports:
//   clock  in  1  rising-edge clock
//   reset  in  1  synchronous reset, loads RESET_VALUE
//   enable in  1  load D on the next edge
//   D      in  N  data in
//   Q      out N  registered data
module sync_register #(
    parameter int unsigned    N           = 32,
    parameter logic [N-1:0]   RESET_VALUE = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [N-1:0]  D,
    output logic [N-1:0]  Q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= RESET_VALUE;
        end else if (enable) begin
            r_q <= D;
        end
    end

    assign Q = r_q;

endmodule : sync_register

// File: rtl/pipeline_skid_buffer.sv
// Module: pipeline_skid_buffer
// Purpose: two-entry valid/ready skid buffer between pipeline stages. in_ready is
//   decoded purely from the state register, so there is no combinational path from
//   out_ready to in_ready, while full throughput is kept when both sides are ready.
// Ports:
//   clock     in   1  rising-edge clock
//   reset     in   1  synchronous active-high reset
//   flush     in   1  synchronous discard of all held words
//   in_valid  in   1  upstream word present
//   in_ready  out  1  buffer accepts in_data this cycle
//   in_data   in   N  upstream data
//   out_valid out  1  out_data holds a valid word
//   out_ready in   1  downstream consumes out_data
//   out_data  out  N  head word (main register)
//   count     out  2  words held (0..2)
module pipeline_skid_buffer
    import skid_pkg::*;
#(
    parameter int unsigned    N           = 32,
    parameter logic [N-1:0]   RESET_VALUE = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_data,
    output logic [COUNT_W-1:0]  count
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_main_en;
    logic            w_skid_en;
    logic [N-1:0]    w_main_d;
    logic [N-1:0]    w_skid_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and data-register enables; flush overrides every handshake
    always_comb begin
        w_state_nxt = r_state;
        w_main_en   = 1'b0;
        w_skid_en   = 1'b0;
        w_main_d    = in_data;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (in_valid) begin
                        w_main_en   = 1'b1;
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_valid && out_ready) begin
                        w_main_en = 1'b1;
                    end else if (in_valid) begin
                        w_skid_en   = 1'b1;
                        w_state_nxt = ST_SKID;
                    end else if (out_ready) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // Refill the head from the overflow word; upstream is stalled
                    w_main_d = w_skid_q;
                    if (out_ready) begin
                        w_main_en   = 1'b1;
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs decode from state only
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        count     = 2'd0;
        case (r_state)
            ST_EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                count     = 2'd0;
            end
            ST_FULL: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                count     = 2'd1;
            end
            ST_SKID: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                count     = 2'd2;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                count     = 2'd0;
            end
        endcase
    end

    sync_register #(
        .N           (N),
        .RESET_VALUE (RESET_VALUE)
    ) u_main_reg (
        .clock  (clock),
        .reset  (reset),
        .enable (w_main_en),
        .D      (w_main_d),
        .Q      (out_data)
    );

    sync_register #(
        .N           (N),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid_reg (
        .clock  (clock),
        .reset  (reset),
        .enable (w_skid_en),
        .D      (in_data),
        .Q      (w_skid_q)
    );

endmodule : pipeline_skid_buffer
